pixel_write_sink: RTL and testbench



---
 rtl/pixel_write_sink_if.sv | 23 ++
 rtl/pixel_write_sink.sv | 147 ++++++++++++++
 tb/tb_pixel_write_sink.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_sink_if.sv
// Pixel stream and framebuffer write port between the drawing engines and pixel_write_sink.
// The master side is the environment (drawing engine plus framebuffer); the slave side is the sink.
interface pixel_write_sink_if;
   logic        plot;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        in_ready;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_ready;

   modport master (
      output plot, x, y, colour, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_data
   );

   modport slave (
      input  plot, x, y, colour, mem_ready,
      output in_ready, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/pixel_write_sink.sv
// Clips incoming pixels, buffers them in a small FIFO and writes them to the framebuffer;
// also sweeps the whole screen with a single colour on request.
module pixel_write_sink #(
   parameter int unsigned SCREEN_W   = 160,
   parameter int unsigned SCREEN_H   = 120,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 resetn,
   pixel_write_sink_if.slave    bus,
   input  logic                 clear_req,
   input  logic [2:0]           clear_colour,
   output logic [15:0]          pix_count,
   output logic [7:0]           clip_count,
   output logic                 overflow,
   output logic                 clear_done,
   output logic                 idle
);
   localparam int unsigned PW        = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_P   = (PW+1)'(FIFO_DEPTH);
   localparam logic [8:0]  W9        = 9'(SCREEN_W);
   localparam logic [7:0]  H8        = 8'(SCREEN_H);
   localparam logic [14:0] W15       = 15'(SCREEN_W);
   localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t        state_q, state_d;
   logic [PW:0]   wr_ptr, rd_ptr;
   logic [17:0]   fifo_mem [FIFO_DEPTH];
   logic          full, empty;
   logic          in_range;
   logic [14:0]   pix_addr;
   logic          we_q;
   logic [14:0]   addr_q;
   logic [2:0]    data_q;
   logic          pending_q;
   logic [2:0]    clr_col_q;
   logic          done_q;
   logic          xfer;
   logic          push, pop, clip, ovf_set, load_clear, sweep_adv, sweep_end;

   assign full     = ((wr_ptr - rd_ptr) == DEPTH_P);
   assign empty    = (wr_ptr == rd_ptr);
   assign in_range = ({1'b0, bus.x} < W9) && ({1'b0, bus.y} < H8);
   assign pix_addr = 15'(bus.y) * W15 + 15'(bus.x);
   assign xfer     = we_q && bus.mem_ready;

   assign bus.mem_we   = we_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_data = data_q;
   assign clear_done   = done_q;
   assign idle         = (state_q == S_IDLE) && empty && !we_q && !pending_q;

   always_ff @(posedge clock) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Out-of-range pixels are clipped even with a full FIFO, so clipping is decided
   // before the full check; only in-range pixels can overflow in IDLE.
   always_comb begin
      state_d      = state_q;
      bus.in_ready = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      clip         = 1'b0;
      ovf_set      = 1'b0;
      load_clear   = 1'b0;
      sweep_adv    = 1'b0;
      sweep_end    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            bus.in_ready = !full;
            if (bus.plot) begin
               if (!in_range) clip    = 1'b1;
               else if (!full) push   = 1'b1;
               else            ovf_set = 1'b1;
            end
            pop = !empty && (!we_q || xfer);
            if (pending_q && empty && !we_q) begin
               state_d    = S_CLEAR;
               load_clear = 1'b1;
            end
         end
         S_CLEAR: begin
            ovf_set = bus.plot;
            if (xfer) begin
               if (addr_q == LAST_ADDR) begin
                  sweep_end = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  sweep_adv = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= {pix_addr, bus.colour};
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         pending_q  <= 1'b0;
         clr_col_q  <= '0;
         done_q     <= 1'b0;
         pix_count  <= '0;
         clip_count <= '0;
         overflow   <= 1'b0;
      end else begin
         done_q <= sweep_end;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr           <= rd_ptr + 1'b1;
            we_q             <= 1'b1;
            {addr_q, data_q} <= fifo_mem[rd_ptr[PW-1:0]];
         end else if (xfer && state_q == S_IDLE) begin
            we_q <= 1'b0;
         end
         if (xfer && state_q == S_IDLE) pix_count <= pix_count + 1'b1;
         if (load_clear) begin
            we_q   <= 1'b1;
            addr_q <= '0;
            data_q <= clr_col_q;
         end
         if (sweep_adv) addr_q <= addr_q + 1'b1;
         if (sweep_end) begin
            we_q      <= 1'b0;
            pending_q <= 1'b0;
         end
         if (clear_req && !pending_q) begin
            pending_q <= 1'b1;
            clr_col_q <= clear_colour;
         end
         if (clip && clip_count != '1) clip_count <= clip_count + 1'b1;
         if (ovf_set) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed bench for pixel_write_sink: vector table plus multi-cycle sequences, with a
// write monitor comparing every completed framebuffer write against an expected queue.
module tb_pixel_write_sink;
   typedef struct packed {
      logic [14:0] a;
      logic [2:0]  d;
   } wr_t;

   typedef struct {
      logic [7:0]  x;
      logic [6:0]  y;
      logic [2:0]  col;
      logic        clip;
      logic [14:0] addr;
   } vec_t;

   logic        clock = 1'b0;
   logic        resetn;
   logic        clear_req;
   logic [2:0]  clear_colour;
   logic [15:0] pix_count;
   logic [7:0]  clip_count;
   logic        overflow;
   logic        clear_done;
   logic        idle;

   pixel_write_sink_if bus();

   pixel_write_sink #(.SCREEN_W(160), .SCREEN_H(120), .FIFO_DEPTH(4)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .bus          (bus.slave),
      .clear_req    (clear_req),
      .clear_colour (clear_colour),
      .pix_count    (pix_count),
      .clip_count   (clip_count),
      .overflow     (overflow),
      .clear_done   (clear_done),
      .idle         (idle)
   );

   always #5 clock = ~clock;

   int    n_cmp = 0;
   int    n_fail = 0;
   wr_t   exp_q[$];
   logic  clr_active = 1'b0;
   logic [2:0] clr_col = '0;
   int    clr_idx = 0;
   int    n_done = 0;
   logic  rand_rdy = 1'b0;
   logic  prev_we = 1'b0;
   logic  prev_rdy = 1'b0;
   logic [14:0] prev_addr = '0;
   logic [2:0]  prev_data = '0;
   wr_t   mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // Completed-write monitor and stall-stability checker (pre-edge values).
   always @(posedge clock) begin
      if (!resetn) begin
         prev_we <= 1'b0;
         clr_idx <= 0;
         n_done  <= 0;
      end else begin
         if (prev_we && !prev_rdy) begin
            check("stall_we", 32'(bus.mem_we), 32'd1);
            check("stall_addr", 32'(bus.mem_addr), 32'(prev_addr));
            check("stall_data", 32'(bus.mem_data), 32'(prev_data));
         end
         if (clear_done) n_done <= n_done + 1;
         if (bus.mem_we && bus.mem_ready) begin
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.a));
               check("wr_data", 32'(bus.mem_data), 32'(mon_e.d));
            end else if (clr_active) begin
               check("clr_addr", 32'(bus.mem_addr), 32'(clr_idx));
               check("clr_data", 32'(bus.mem_data), 32'(clr_col));
               clr_idx <= clr_idx + 1;
            end else begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0d expected no write", bus.mem_addr);
            end
         end
         prev_we   <= bus.mem_we;
         prev_rdy  <= bus.mem_ready;
         prev_addr <= bus.mem_addr;
         prev_data <= bus.mem_data;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_rdy) bus.mem_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      exp_q.delete();
      clr_active = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!idle && n < budget) begin
         tick();
         n++;
      end
      check("idle_timeout", 32'(idle), 32'd1);
   endtask

   task automatic drive_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
      logic acc;
      acc = bus.in_ready;
      bus.plot = 1'b1;
      bus.x = px;
      bus.y = py;
      bus.colour = pc;
      if (acc && px < 8'd160 && py < 7'd120)
         exp_q.push_back(wr_t'{a: 15'(int'(py) * 160 + int'(px)), d: pc});
      tick();
      bus.plot = 1'b0;
   endtask

   vec_t vecs[10];

   initial begin
      int clip_exp;
      int pix0;
      int n;
      int accepted;

      vecs[0] = '{x: 8'd0,   y: 7'd0,   col: 3'd1, clip: 1'b0, addr: 15'd0};
      vecs[1] = '{x: 8'd160, y: 7'd0,   col: 3'd2, clip: 1'b1, addr: 15'd0};
      vecs[2] = '{x: 8'd0,   y: 7'd120, col: 3'd3, clip: 1'b1, addr: 15'd0};
      vecs[3] = '{x: 8'd159, y: 7'd119, col: 3'd4, clip: 1'b0, addr: 15'd19199};
      vecs[4] = '{x: 8'd1,   y: 7'd1,   col: 3'd5, clip: 1'b0, addr: 15'd161};
      vecs[5] = '{x: 8'd255, y: 7'd127, col: 3'd6, clip: 1'b1, addr: 15'd0};
      vecs[6] = '{x: 8'd100, y: 7'd50,  col: 3'd7, clip: 1'b0, addr: 15'd8100};
      vecs[7] = '{x: 8'd159, y: 7'd0,   col: 3'd2, clip: 1'b0, addr: 15'd159};
      vecs[8] = '{x: 8'd0,   y: 7'd119, col: 3'd3, clip: 1'b0, addr: 15'd19040};
      vecs[9] = '{x: 8'd5,   y: 7'd120, col: 3'd1, clip: 1'b1, addr: 15'd0};

      resetn = 1'b0;
      bus.plot = 1'b0;
      bus.x = '0;
      bus.y = '0;
      bus.colour = '0;
      bus.mem_ready = 1'b0;
      clear_req = 1'b0;
      clear_colour = '0;
      tick();
      tick();
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_data", 32'(bus.mem_data), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_clear_done", 32'(clear_done), 32'd0);
      check("rst_pix_count", 32'(pix_count), 32'd0);
      check("rst_clip_count", 32'(clip_count), 32'd0);
      resetn = 1'b1;

      // Single pixel latency
      bus.mem_ready = 1'b1;
      bus.plot = 1'b1; bus.x = 8'd5; bus.y = 7'd2; bus.colour = 3'b011;
      exp_q.push_back(wr_t'{a: 15'd325, d: 3'd3});
      tick();
      bus.plot = 1'b0;
      check("lat_we_n1", 32'(bus.mem_we), 32'd0);
      tick();
      check("lat_we_n2", 32'(bus.mem_we), 32'd1);
      check("lat_addr", 32'(bus.mem_addr), 32'd325);
      check("lat_data", 32'(bus.mem_data), 32'd3);
      tick();
      check("lat_we_n3", 32'(bus.mem_we), 32'd0);
      check("lat_pix_count", 32'(pix_count), 32'd1);

      // Vector table
      clip_exp = 0;
      foreach (vecs[i]) begin
         wait_idle(50);
         pix0 = int'(pix_count);
         if (!vecs[i].clip) exp_q.push_back(wr_t'{a: vecs[i].addr, d: vecs[i].col});
         bus.plot = 1'b1; bus.x = vecs[i].x; bus.y = vecs[i].y; bus.colour = vecs[i].col;
         tick();
         bus.plot = 1'b0;
         wait_idle(50);
         if (vecs[i].clip) clip_exp++;
         check("vec_clip_count", 32'(clip_count), 32'(clip_exp));
         check("vec_pix_count", 32'(pix_count), 32'(pix0 + (vecs[i].clip ? 0 : 1)));
         check("vec_queue_drained", 32'(exp_q.size()), 32'd0);
      end

      // Backpressure: 5 accepted (4 FIFO + 1 register), 6th overflows
      do_reset();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("bp_in_ready", 32'(bus.in_ready), (i < 5) ? 32'd1 : 32'd0);
         drive_plot(8'(i), 7'd0, 3'(i));
      end
      check("bp_overflow", 32'(overflow), 32'd1);
      tick(); tick();
      check("bp_hold_we", 32'(bus.mem_we), 32'd1);
      check("bp_hold_addr", 32'(bus.mem_addr), 32'd0);
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_b2b_pix", 32'(pix_count), 32'(k + 1));
      end
      check("bp_we_low", 32'(bus.mem_we), 32'd0);
      check("bp_idle", 32'(idle), 32'd1);
      check("bp_queue_drained", 32'(exp_q.size()), 32'd0);

      // Clip saturation
      do_reset();
      bus.plot = 1'b1; bus.x = 8'd200; bus.y = 7'd0;
      repeat (254) tick();
      check("clip_254", 32'(clip_count), 32'd254);
      repeat (46) tick();
      bus.plot = 1'b0;
      check("clip_sat", 32'(clip_count), 32'd255);
      check("clip_no_overflow", 32'(overflow), 32'd0);

      // Clear sweep behind three queued pixels
      do_reset();
      bus.mem_ready = 1'b0;
      drive_plot(8'd10, 7'd0, 3'd1);
      drive_plot(8'd11, 7'd0, 3'd2);
      drive_plot(8'd12, 7'd0, 3'd4);
      clr_col = 3'd7;
      clear_req = 1'b1; clear_colour = 3'b111;
      tick();
      clear_req = 1'b0; clear_colour = 3'd0;
      repeat (3) tick();
      clear_req = 1'b1; clear_colour = 3'd2;
      tick();
      clear_req = 1'b0;
      clr_active = 1'b1;
      bus.mem_ready = 1'b1;
      n = 0;
      while (!clear_done && n < 25000) begin
         if (n == 100) begin
            check("clr_in_ready", 32'(bus.in_ready), 32'd0);
            drive_plot(8'd10, 7'd10, 3'd3);
         end else begin
            tick();
         end
         n++;
      end
      check("clr_done_seen", 32'(clear_done), 32'd1);
      check("clr_count", 32'(clr_idx), 32'd19200);
      check("clr_we_low", 32'(bus.mem_we), 32'd0);
      check("clr_pix_count", 32'(pix_count), 32'd3);
      check("clr_overflow", 32'(overflow), 32'd1);
      tick();
      check("clr_done_pulse", 32'(clear_done), 32'd0);
      tick(); tick();
      check("clr_done_once", 32'(n_done), 32'd1);
      check("clr_idle", 32'(idle), 32'd1);
      clr_active = 1'b0;

      // Reset in the middle of a sweep
      do_reset();
      bus.mem_ready = 1'b1;
      clr_col = 3'd5;
      clr_active = 1'b1;
      clear_req = 1'b1; clear_colour = 3'd5;
      tick();
      clear_req = 1'b0;
      n = 0;
      while (!(bus.mem_we && bus.mem_addr == 15'd500) && n < 1000) begin
         tick();
         n++;
      end
      check("mid_reach_500", 32'(bus.mem_addr), 32'd500);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      clr_active = 1'b0;
      check("mid_we", 32'(bus.mem_we), 32'd0);
      check("mid_addr", 32'(bus.mem_addr), 32'd0);
      check("mid_idle", 32'(idle), 32'd1);
      check("mid_pix", 32'(pix_count), 32'd0);
      check("mid_clip", 32'(clip_count), 32'd0);
      drive_plot(8'd1, 7'd1, 3'd6);
      wait_idle(50);
      check("mid_after_pix", 32'(pix_count), 32'd1);
      check("mid_queue_drained", 32'(exp_q.size()), 32'd0);

      // Random mem_ready over 1000 accepted pixels
      do_reset();
      rand_rdy = 1'b1;
      accepted = 0;
      n = 0;
      while (accepted < 1000 && n < 20000) begin
         if (bus.in_ready) begin
            drive_plot(8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)),
                       3'($urandom_range(0, 7)));
            accepted++;
         end else begin
            tick();
         end
         n++;
      end
      check("rand_accepted", 32'(accepted), 32'd1000);
      wait_idle(5000);
      rand_rdy = 1'b0;
      bus.mem_ready = 1'b0;
      check("rand_pix_count", 32'(pix_count), 32'd1000);
      check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
      check("rand_overflow", 32'(overflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
